// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - resource-shared AES SubBytes, NSBOX bytes per cycle, valid/ready on both sides
// Optional inverse S-box support is built when AES_SBOX_INV_EN is defined.
module aes_sub_bytes_seq #(
    parameter int LANES = 16,
    parameter int NSBOX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv
);
    localparam int CHUNKS = LANES / NSBOX;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    // Tables are written entry 0 first, so entry x sits at packed index ~x.
    localparam logic [255:0][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef AES_SBOX_INV_EN
    localparam logic INV_EN = 1'b1;
    localparam logic [255:0][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
`else
    localparam logic INV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                           state;
    logic [CHUNKS-1:0][8*NSBOX-1:0]   wreg;
    logic                             mreg;
    logic [CW-1:0]                    cnt;
    logic [8*NSBOX-1:0]               chunk;
    logic [8*NSBOX-1:0]               sub;
    logic                             accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_data = wreg;
    assign out_inv  = mreg;
    assign chunk    = wreg[cnt];

    for (genvar i = 0; i < NSBOX; i++) begin : g_sbox
        logic [7:0] b;
        assign b = chunk[8*i +: 8];
`ifdef AES_SBOX_INV_EN
        assign sub[8*i +: 8] = mreg ? SBOX_INV[~b] : SBOX_FWD[~b];
`else
        assign sub[8*i +: 8] = SBOX_FWD[~b];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wreg      <= '0;
            mreg      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wreg  <= in_data;
                        mreg  <= INV_EN & in_inv;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    wreg[cnt] <= sub;
                    cnt       <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Back-to-back accept keeps the engine busy without an idle bubble.
                        if (accept) begin
                            wreg  <= in_data;
                            mreg  <= INV_EN & in_inv;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb/tb_aes_sub_bytes_seq.sv - directed self-checking bench for aes_sub_bytes_seq
module tb_aes_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    localparam logic [255:0][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_sub_bytes_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv)
    );

    localparam int CFG_L [4] = '{16, 16, 4, 4};
    localparam int CFG_N [4] = '{16, 1, 4, 2};

    logic [127:0] sw_in  [4];
    logic [127:0] sw_out [4];
    logic [3:0]   sw_iv, sw_ir, sw_ov, sw_or, sw_oi;

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int L = CFG_L[g];
        localparam int N = CFG_N[g];
        logic [8*L-1:0] od;
        aes_sub_bytes_seq #(.LANES(L), .NSBOX(N)) u_sw (
            .clk(clk), .rst_n(rst_n),
            .in_valid(sw_iv[g]), .in_ready(sw_ir[g]), .in_data(sw_in[g][8*L-1:0]), .in_inv(1'b0),
            .out_valid(sw_ov[g]), .out_ready(sw_or[g]), .out_data(od), .out_inv(sw_oi[g])
        );
        assign sw_out[g] = 128'(od);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic inv);
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic sweep(input int g);
        int           lanes, lat, cyc;
        logic [127:0] w, e;
        lanes = CFG_L[g];
        lat   = CFG_L[g] / CFG_N[g];
        sw_or[g] = 1'b1;
        for (int wi = 0; wi < 256 / lanes; wi++) begin
            w = '0;
            e = '0;
            for (int k = 0; k < lanes; k++) begin
                w[8*k +: 8] = 8'(wi * lanes + k);
                e[8*k +: 8] = FWD[8'(255 - (wi * lanes + k))];
            end
            sw_in[g] = w;
            sw_iv[g] = 1'b1;
            #1;
            check($sformatf("sw%0d_ready", g), 128'(sw_ir[g]), 128'd1);
            @(posedge clk); #1;
            sw_iv[g] = 1'b0;
            cyc = 0;
            while (!sw_ov[g] && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("sw%0d_lat", g), 128'(cyc), 128'(lat));
            check($sformatf("sw%0d_data_w%0d", g, wi), sw_out[g], e);
            check($sformatf("sw%0d_inv", g), 128'(sw_oi[g]), 128'd0);
        end
        @(posedge clk); #1;
        sw_or[g] = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
        sw_iv = '0; sw_or = '0;
        for (int g = 0; g < 4; g++) sw_in[g] = '0;

        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_inv", 128'(out_inv), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(128'h000000000000000000bee33d19ff5300, 1'b0);
        check("busy_in_ready", 128'(in_ready), 128'd0);
        wait_out(cyc);
        check("fwd_lat", 128'(cyc), 128'd4);
        check("fwd_data", out_data, 128'h636363636363636363ae1127d416ed63);
        check("fwd_inv", 128'(out_inv), 128'd0);
        consume();
        check("idle_out_valid", 128'(out_valid), 128'd0);

        send(128'h636363636363636363636363d416ed63, 1'b1);
        wait_out(cyc);
        check("inv_lat", 128'(cyc), 128'd4);
`ifdef AES_SBOX_INV_EN
        check("inv_data", out_data, 128'h00000000000000000000000019ff5300);
        check("inv_flag", 128'(out_inv), 128'd1);
`else
        check("inv_data", out_data, 128'hfbfbfbfbfbfbfbfbfbfbfbfb484755fb);
        check("inv_flag", 128'(out_inv), 128'd0);
`endif
        consume();

        send({16{8'h53}}, 1'b0);
        wait_out(cyc);
        check("bp_lat", 128'(cyc), 128'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_data", out_data, {16{8'hed}});
            check("bp_hold_ready", 128'(in_ready), 128'd0);
            check("bp_hold_valid", 128'(out_valid), 128'd1);
        end
        in_data = {16{8'h01}}; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_release_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_after_valid", 128'(out_valid), 128'd0);
        wait_out(cyc);
        check("bp_second_lat", 128'(cyc), 128'd4);
        check("bp_second_data", out_data, {16{8'h7c}});
        consume();

        send({16{8'hff}}, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_out_data", out_data, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send({16{8'h01}}, 1'b0);
        wait_out(cyc);
        check("post_rst_lat", 128'(cyc), 128'd4);
        check("post_rst_data", out_data, {16{8'h7c}});
        consume();

        for (int g = 0; g < 4; g++) sweep(g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_sub_bytes_seq.md
# aes_sub_bytes_seq

Multi-lane, resource-shared AES SubBytes engine with a valid/ready handshake on both sides. It accepts a word of `LANES` bytes and substitutes it through `NSBOX` physical S-box instances, `NSBOX` bytes per cycle. It then presents the substituted word until the consumer takes it. It sits between the round-state register and ShiftRows in the iterative AES datapath, and serves key expansion (SubWord, `LANES`=4) when instantiated narrow.

## Interface
Parameters:
- `LANES`, 16, bytes per word; must be a multiple of `NSBOX`.
- `NSBOX`, 4, S-box instances (bytes substituted per cycle); 1 ≤ `NSBOX` ≤ `LANES`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word offered.
- `in_ready`  out  1  engine can accept a word this cycle.
- `in_data`  in  8*LANES  input word; byte k = `in_data[8k+7:8k]`.
- `in_inv`  in  1  1 = inverse S-box for this word, 0 = forward.
- `out_valid`  out  1  substituted word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  8*LANES  substituted word, same byte ordering.
- `out_inv`  out  1  mode the word was processed with.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Word register `wreg` (8*LANES), mode flag `mreg`, chunk counter `cnt` (width clog2(LANES/NSBOX), min 1).
- `in_ready` is combinational: 1 in IDLE, 1 in DONE when `out_ready`=1, 0 in BUSY.
- Accept (`in_valid & in_ready`):
  - load `wreg`←`in_data` and `mreg`←`in_inv`;
  - clear `cnt`;
  - go to BUSY.
- BUSY, each cycle:
  - bytes [`cnt`*NSBOX .. `cnt`*NSBOX+NSBOX-1] of `wreg` pass through the S-boxes (forward, or inverse when `mreg`=1) and are written back in place;
  - `cnt` increments.
  - On the last chunk (`cnt` = LANES/NSBOX-1) go to DONE.
- DONE:
  - `out_valid`=1, `out_data`=`wreg`, `out_inv`=`mreg`, held stable until `out_ready`=1.
  - On `out_ready` without a new accept: go to IDLE.
  - On `out_ready` with a simultaneous accept: load the new word and go to BUSY (no bubble).
- IDLE/BUSY: `out_valid`=0. `out_data` reflects `wreg` but is don't-care for the consumer.
- S-box functions: the FIPS-197 forward table, and its exact inverse under `AES_SBOX_INV_EN`. Byte lanes are independent; there is no cross-byte arithmetic.
- `in_valid` while BUSY is ignored. The source must hold the word until `in_ready`.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and the partially substituted word is discarded.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_inv`=0, `wreg`=0, `cnt`=0. `in_ready`=1 during and after reset.
- Latency: accept at edge N puts `out_valid`=1 after edge N+LANES/NSBOX (4 cycles at defaults; 1 cycle when `NSBOX`=`LANES`).
- Throughput: one word per LANES/NSBOX cycles with `out_ready` held high.
- S-box lookup is combinational within the BUSY cycle, so the critical path is wreg→mux→S-box→wreg.
- `out_ready` without `out_valid` has no effect.

## Configuration
- `AES_SBOX_INV_EN` defined: `NSBOX` inverse S-box instances are built, and `mreg` selects forward or inverse per word.
- Not defined: no inverse tables are synthesised, `in_inv` is ignored, `mreg` is forced to 0, `out_inv` is always 0, and all words are substituted forward.

## Test plan
- Reset, then one word at defaults with bytes 0x00,0x53,0xff,0x19,0x3d,0xe3,0xbe, rest 0x00 -> after 4 cycles `out_valid`=1; bytes 0x63,0xed,0x16,0xd4,0x27,0x11,0xae, rest 0x63; `out_inv`=0.
- With `AES_SBOX_INV_EN`: `in_inv`=1, bytes 0x63,0xed,0x16,0xd4 (rest 0x63) -> 0x00,0x53,0xff,0x19 (rest 0x00); `out_inv`=1. Without the macro, the same stimulus gives forward results and `out_inv`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_data` stable, `in_ready`=0; release -> one transfer; a second word offered in the same cycle is accepted (`in_ready`=1) and its output appears 4 cycles later.
- Sweep parameters (`LANES`,`NSBOX`) = (16,16), (16,1), (4,4), (4,2) with all 256 byte values across words -> output equals the table lookup; latency is 1, 16, 1 and 2 cycles respectively.
- Assert `rst_n` low during BUSY cycle 2 -> `out_valid` 0 immediately and `in_ready`=1. After release, a fresh word 0x01.. produces 0x7c.. with the full 4-cycle latency and no residue from the aborted word.
